// File: rtl/led_matrix_row_scanner_pkg.sv
// Shared panel definitions for the LED matrix row scanner and its row mux.
// Contents:
//   PANEL_ROWS / PANEL_COLS : default panel geometry (7 rows x 5 columns)
//   SEL_W                   : width of the row-select bus consumed by the 7:1 row mux
//   scan_state_e            : scanner FSM states (blanking gap / row drive)
//   cnt_width()             : width of the dwell/blank counter for a given timing
package led_matrix_row_scanner_pkg;

  localparam int PANEL_ROWS = 7;
  localparam int PANEL_COLS = 5;
  localparam int SEL_W      = 3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // clog2 of the longer of the two phases, never narrower than one bit.
  function automatic int cnt_width(input int dwell_cyc, input int blank_cyc);
    int m;
    int w;
    m = (dwell_cyc > blank_cyc) ? dwell_cyc : blank_cyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_matrix_row_scanner_scan_timer.sv
// Loadable down-counter used to time the blanking and drive phases.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous clear, active-high; returns the count to CLR_VAL
//   load_i     : load load_val_i on the next edge (takes priority over counting)
//   load_val_i : value to load; a phase of N cycles is loaded with N-1
//   tc_o       : terminal count, high while the count is zero
// The counter stops at zero; it never wraps on its own.
module led_matrix_row_scanner_scan_timer #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CLR_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_row_scanner.sv
// Row scanner for the LED matrix: holds a double-buffered frame and scans it
// row by row, inserting an all-off blanking gap between rows to avoid ghosting.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high
//   enable     : 1 = scan; 0 = blank the display and park at row 0
//   frame_in   : new frame, row r at frame_in[r*COLS +: COLS], row 0 on top
//   load       : one-cycle strobe capturing frame_in into the shadow buffer
//   pending    : shadow buffer holds a frame not yet displayed
//   sel        : current row index for the row mux (0 selects linha[6])
//   row_en     : one-hot row enable, row idx on bit [ROWS-1-idx]; 0 while blanking
//   col        : column data of the driven row; 0 while blanking
//   frame_done : one-cycle pulse on the first blanking cycle after the last row
// All outputs come straight from registers.
module led_matrix_row_scanner
  import led_matrix_row_scanner_pkg::*;
#(
  parameter int ROWS      = PANEL_ROWS,
  parameter int COLS      = PANEL_COLS,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 load,
  output logic                 pending,
  output logic [SEL_W-1:0]     sel,
  output logic [ROWS-1:0]      row_en,
  output logic [COLS-1:0]      col,
  output logic                 frame_done
);

  localparam int               CNT_W    = cnt_width(DWELL_CYC, BLANK_CYC);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(ROWS - 1);

  scan_state_e            state_q;
  logic [SEL_W-1:0]       idx_q;
  logic [SEL_W-1:0]       idx_d;
  logic [ROWS*COLS-1:0]   active_q;
  logic [ROWS*COLS-1:0]   shadow_q;
  logic                   pending_q;
  logic [SEL_W-1:0]       sel_q;
  logic [ROWS-1:0]        row_en_q;
  logic [COLS-1:0]        col_q;
  logic                   frame_done_q;

  logic                   tc;
  logic                   wrap;
  logic                   timer_load;
  logic [CNT_W-1:0]       timer_val;
  logic [COLS-1:0]        act_rows [ROWS];

  function automatic logic [ROWS-1:0] row_onehot(input logic [SEL_W-1:0] i);
    logic [ROWS-1:0] v;
    v = '0;
    for (int b = 0; b < ROWS; b++) begin
      if (i == SEL_W'(ROWS - 1 - b)) v[b] = 1'b1;
    end
    return v;
  endfunction

  for (genvar g = 0; g < ROWS; g++) begin : g_rows
    assign act_rows[g] = active_q[g*COLS +: COLS];
  end

  // The timer resets to the blank reload value so the first blanking gap
  // after reset is a full BLANK_CYC long.
  led_matrix_row_scanner_scan_timer #(
    .W       (CNT_W),
    .CLR_VAL (BLANK_LD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tc_o       (tc)
  );

  assign idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
  // Last drive cycle of the last row: the only edge where a buffer swap may occur.
  assign wrap  = enable && (state_q == ST_DRIVE) && tc && (idx_q == LAST_IDX);

  // Reload on every phase change; while disabled keep it primed for a full blank.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = BLANK_LD;
    if (!enable) begin
      timer_load = 1'b1;
    end else if (tc) begin
      timer_load = 1'b1;
      timer_val  = (state_q == ST_BLANK) ? DWELL_LD : BLANK_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      sel_q        <= '0;
      row_en_q     <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // Swap reads the pre-edge shadow, so a load on the wrap edge queues
      // behind the frame being promoted.
      if (wrap && pending_q) active_q <= shadow_q;
      if (load) begin
        shadow_q  <= frame_in;
        pending_q <= 1'b1;
      end else if (wrap && pending_q) begin
        pending_q <= 1'b0;
      end

      if (!enable) begin
        state_q  <= ST_BLANK;
        idx_q    <= '0;
        sel_q    <= '0;
        row_en_q <= '0;
        col_q    <= '0;
      end else if (tc) begin
        if (state_q == ST_BLANK) begin
          state_q  <= ST_DRIVE;
          sel_q    <= idx_q;
          row_en_q <= row_onehot(idx_q);
          col_q    <= act_rows[idx_q];
        end else begin
          state_q      <= ST_BLANK;
          idx_q        <= idx_d;
          sel_q        <= idx_d;
          row_en_q     <= '0;
          col_q        <= '0;
          frame_done_q <= (idx_q == LAST_IDX);
        end
      end
    end
  end

  assign pending    = pending_q;
  assign sel        = sel_q;
  assign row_en     = row_en_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_row_scanner.sv
module tb_led_matrix_row_scanner;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int DWELL = 3;
  localparam int BLANK = 1;
  localparam int RP    = BLANK + DWELL;   // row period
  localparam int FP    = ROWS * RP;       // frame period

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 load;
  logic [ROWS*COLS-1:0] frame_in;
  logic                 pending;
  logic [2:0]           sel;
  logic [ROWS-1:0]      row_en;
  logic [COLS-1:0]      col;
  logic                 frame_done;

  always #5 clk = ~clk;

  led_matrix_row_scanner #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .DWELL_CYC (DWELL),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_in   (frame_in),
    .load       (load),
    .pending    (pending),
    .sel        (sel),
    .row_en     (row_en),
    .col        (col),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Frame whose row r holds (base + step*r) truncated to COLS bits.
  function automatic logic [ROWS*COLS-1:0] mk_frame(input int base, input int step);
    logic [ROWS*COLS-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) begin
      f = f | ((35'(base + step * r) & 35'h1F) << (r * COLS));
    end
    return f;
  endfunction

  // Timeline model: m_t counts cycles since the scan (re)started, t=0 being the
  // first blanking cycle of row 0. Everything visible follows from t by division.
  int                   m_t = 0;
  logic [ROWS*COLS-1:0] m_active = '0;
  logic [ROWS*COLS-1:0] m_shadow = '0;
  logic                 m_pend = 1'b0;
  logic                 m_fd = 1'b0;
  logic                 m_valid = 1'b0;
  logic                 m_wrap;

  assign m_wrap = enable && ((m_t % FP) == FP - 1);

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_t      <= 0;
      m_active <= '0;
      m_shadow <= '0;
      m_pend   <= 1'b0;
      m_fd     <= 1'b0;
    end else begin
      m_active <= (m_wrap && m_pend) ? m_shadow : m_active;
      m_shadow <= load ? frame_in : m_shadow;
      m_pend   <= load ? 1'b1 : ((m_wrap && m_pend) ? 1'b0 : m_pend);
      m_t      <= enable ? m_t + 1 : 0;
      m_fd     <= enable && (((m_t + 1) % FP) == 0);
    end
  end

  function automatic int exp_row(input int t);
    return (t / RP) % ROWS;
  endfunction

  function automatic bit exp_drive(input int t);
    return (t % RP) >= BLANK;
  endfunction

  function automatic logic [ROWS-1:0] exp_row_en(input int t);
    logic [ROWS-1:0] v;
    v = '0;
    if (exp_drive(t)) v[ROWS - 1 - exp_row(t)] = 1'b1;
    return v;
  endfunction

  function automatic logic [COLS-1:0] exp_col(input int t, input logic [ROWS*COLS-1:0] a);
    logic [ROWS*COLS-1:0] s;
    s = a >> (exp_row(t) * COLS);
    return exp_drive(t) ? s[COLS-1:0] : '0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("sel",        32'(sel),        32'(exp_row(m_t)));
      check("row_en",     32'(row_en),     32'(exp_row_en(m_t)));
      check("col",        32'(col),        32'(exp_col(m_t, m_active)));
      check("pending",    32'(pending),    32'(m_pend));
      check("frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while (m_t != target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (m_t != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_t: reached t=%0d, expected t=%0d", m_t, target);
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    frame_in = '0;

    // Reset held for two edges
    repeat (2) @(negedge clk);
    check("rst_sel",    32'(sel),        32'd0);
    check("rst_row_en", 32'(row_en),     32'd0);
    check("rst_col",    32'(col),        32'd0);
    check("rst_pend",   32'(pending),    32'd0);
    check("rst_fd",     32'(frame_done), 32'd0);

    // Release, start scanning, queue frame with row r = r+1
    rst      = 1'b0;
    enable   = 1'b1;
    load     = 1'b1;
    frame_in = mk_frame(1, 1);
    @(negedge clk);
    load = 1'b0;
    check("t1_row_en", 32'(row_en),  32'h40);
    check("t1_col",    32'(col),     32'd0);
    check("t1_pend",   32'(pending), 32'd1);

    wait_t(28);
    check("f1_done", 32'(frame_done), 32'd1);
    check("f1_pend", 32'(pending),    32'd0);
    wait_t(29);
    check("r0_col", 32'(col), 32'd1);
    wait_t(33);
    check("r1_sel",    32'(sel),    32'd1);
    check("r1_row_en", 32'(row_en), 32'h20);
    check("r1_col",    32'(col),    32'd2);
    wait_t(52);
    check("r6_blank_sel", 32'(sel), 32'd6);
    check("r6_blank_col", 32'(col), 32'd0);
    wait_t(53);
    check("r6_col",    32'(col),    32'd7);
    check("r6_row_en", 32'(row_en), 32'h01);
    wait_t(56);
    check("f2_done", 32'(frame_done), 32'd1);
    wait_t(57);
    check("f2_done_low", 32'(frame_done), 32'd0);

    // Mid-frame load during row 3
    wait_t(68);
    load     = 1'b1;
    frame_in = mk_frame(31, 0);
    wait_t(69);
    load = 1'b0;
    check("mid_pend", 32'(pending), 32'd1);
    check("mid_r3",   32'(col),     32'd4);
    wait_t(73);
    check("mid_r4_old", 32'(col), 32'd5);
    wait_t(84);
    check("mid_swap_pend", 32'(pending),    32'd0);
    check("mid_swap_done", 32'(frame_done), 32'd1);
    wait_t(85);
    check("mid_new_r0", 32'(col), 32'h1F);

    // Load coincident with wrap while nothing pending
    wait_t(111);
    load     = 1'b1;
    frame_in = mk_frame(10, 0);
    wait_t(112);
    load = 1'b0;
    check("co_done", 32'(frame_done), 32'd1);
    check("co_pend", 32'(pending),    32'd1);
    wait_t(113);
    check("co_keep_a", 32'(col), 32'h1F);
    wait_t(140);
    check("co_pend_clr", 32'(pending), 32'd0);
    wait_t(141);
    check("co_show_b", 32'(col), 32'h0A);

    // Load coincident with wrap while a frame is pending
    wait_t(145);
    load     = 1'b1;
    frame_in = mk_frame(16, 1);
    wait_t(146);
    load = 1'b0;
    wait_t(167);
    load     = 1'b1;
    frame_in = mk_frame(7, 0);
    wait_t(168);
    load = 1'b0;
    check("cp_pend", 32'(pending),    32'd1);
    check("cp_done", 32'(frame_done), 32'd1);
    wait_t(169);
    check("cp_show_c", 32'(col), 32'd16);
    wait_t(197);
    check("cp_show_d", 32'(col), 32'd7);

    // Enable drop during drive of row 4, load while disabled
    wait_t(213);
    enable = 1'b0;
    @(negedge clk);
    check("dis_row_en", 32'(row_en),     32'd0);
    check("dis_sel",    32'(sel),        32'd0);
    check("dis_fd",     32'(frame_done), 32'd0);
    load     = 1'b1;
    frame_in = mk_frame(24, 0);
    @(negedge clk);
    load = 1'b0;
    check("dis_load_pend", 32'(pending), 32'd1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen_row_en", 32'(row_en),  32'h40);
    check("reen_col",    32'(col),     32'd7);
    check("reen_pend",   32'(pending), 32'd1);

    // Reset during drive of row 5 with a frame pending
    wait_t(21);
    check("pre_rst_sel", 32'(sel), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_row_en", 32'(row_en),     32'd0);
    check("mrst_col",    32'(col),        32'd0);
    check("mrst_sel",    32'(sel),        32'd0);
    check("mrst_pend",   32'(pending),    32'd0);
    check("mrst_fd",     32'(frame_done), 32'd0);
    wait_t(1);
    check("mrst_r0_en",  32'(row_en), 32'h40);
    check("mrst_r0_col", 32'(col),    32'd0);
    wait_t(29);
    check("mrst_f2_col", 32'(col), 32'd0);
    wait_t(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
